// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and its matching transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-clk pulse every DIV clocks, never resynced to line activity.
// Latency: first tick DIV clocks after reset release; no backpressure.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver; ready/frame_err pulse 1 clk after the stop-bit sample tick.
// No backpressure: RxD_data holds the last good byte and is overwritten by the next one.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxD_data,
  output logic                 RxD_data_ready,
  output logic                 RxD_frame_err,
  output logic                 RxD_idle
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] S_HALF = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  B_LAST = BW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  logic sync1, rxs, tick;
  uart_state_t state, state_n;
  logic [SCW-1:0] scnt, scnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic load, ferr;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Line idles high, so the synchronizer resets high to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RxD;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      scnt           <= '0;
      bidx           <= '0;
      shift_reg      <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
    end else begin
      state          <= state_n;
      scnt           <= scnt_n;
      bidx           <= bidx_n;
      shift_reg      <= shift_n;
      RxD_data_ready <= load;
      RxD_frame_err  <= ferr;
      if (load) RxD_data <= shift_reg;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bidx_n  = bidx;
    shift_n = shift_reg;
    load    = 1'b0;
    ferr    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            scnt_n  = '0;
          end
        end
        START: begin
          // Mid-point recheck rejects glitches shorter than half a bit.
          if (scnt == S_HALF) begin
            scnt_n = '0;
            bidx_n = '0;
            state_n = rxs ? IDLE : DATA;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        DATA: begin
          if (scnt == S_LAST) begin
            scnt_n  = '0;
            shift_n = {rxs, shift_reg[DATA_BITS-1:1]};
            bidx_n  = bidx + 1'b1;
            if (bidx == B_LAST) state_n = STOP;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        STOP: begin
          if (scnt == S_LAST) begin
            scnt_n = '0;
            if (rxs) begin
              load    = 1'b1;
              state_n = IDLE;
            end else begin
              ferr    = 1'b1;
              state_n = BREAK;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign RxD_idle = (state == IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a byte-queue reference model of the serial line.
module tb_uart_rx;

  localparam int BP = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_idle;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int err_cnt = 0, err_exp = 0;
  int overlap = 0, wide = 0;
  bit busy_seen = 0;
  bit prev_rdy = 0, prev_err = 0;

  uart_rx #(.CLK_FREQ(50000000), .BAUD(115200), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxD           (RxD),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_frame_err (RxD_frame_err),
    .RxD_idle      (RxD_idle)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (RxD_data_ready) got_q.push_back(RxD_data);
      if (RxD_frame_err) err_cnt++;
      if (RxD_data_ready && RxD_frame_err) overlap++;
      if ((RxD_data_ready && prev_rdy) || (RxD_frame_err && prev_err)) wide++;
      if (!RxD_idle) busy_seen = 1;
      prev_rdy = RxD_data_ready;
      prev_err = RxD_frame_err;
    end else begin
      prev_rdy = 0;
      prev_err = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line_for(input logic v, input int clks);
    RxD = v;
    repeat (clks) @(posedge clk);
  endtask

  // The model: a good frame delivers its byte, a low stop bit delivers an error instead.
  task automatic send_frame(input logic [7:0] b, input int bp, input logic stop);
    line_for(1'b0, bp);
    for (int i = 0; i < 8; i++) line_for(b[i], bp);
    line_for(stop, bp);
    if (stop) exp_q.push_back(b);
    else err_exp++;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, err_cnt, err_exp);
  endtask

  initial begin
    logic [7:0] rb;
    int bp;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 1'b0);
    check("rst_err", RxD_frame_err, 1'b0);
    check("rst_idle", RxD_idle, 1'b1);
    rst_n = 1'b1;
    line_for(1'b1, 2 * BP);

    // Single frame
    busy_seen = 0;
    send_frame(8'h41, BP, 1'b1);
    line_for(1'b1, 2 * BP);
    check("t1_busy_seen", busy_seen, 1'b1);
    @(negedge clk);
    check("t1_idle_after", RxD_idle, 1'b1);
    check("t1_data_hold", RxD_data, 8'h41);
    check_rx("t1");

    // Back-to-back frames with no idle gap
    send_frame(8'hC8, BP, 1'b1);
    send_frame(8'h65, BP, 1'b1);
    send_frame(8'h6C, BP, 1'b1);
    line_for(1'b1, 2 * BP);
    check_rx("t2");

    // Held-low line: one error, data retained
    line_for(1'b0, 11 * BP);
    err_exp++;
    line_for(1'b1, 2 * BP);
    @(negedge clk);
    check("t3_idle", RxD_idle, 1'b1);
    check("t3_data_hold", RxD_data, 8'h6C);
    check_rx("t3");

    // Short glitch then a real frame
    line_for(1'b0, 100);
    line_for(1'b1, BP);
    @(negedge clk);
    check("t4_idle_glitch", RxD_idle, 1'b1);
    check("t4_no_rx", got_q.size(), 0);
    send_frame(8'h55, BP, 1'b1);
    line_for(1'b1, 2 * BP);
    check_rx("t4");

    // Reset asserted during bit 4 of 0xAA
    rb = 8'hAA;
    line_for(1'b0, BP);
    for (int i = 0; i < 4; i++) line_for(rb[i], BP);
    line_for(rb[4], 200);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_data", RxD_data, 8'h00);
    check("t5_rst_ready", RxD_data_ready, 1'b0);
    check("t5_rst_err", RxD_frame_err, 1'b0);
    check("t5_rst_idle", RxD_idle, 1'b1);
    RxD = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    line_for(1'b1, 2 * BP);
    send_frame(8'h0F, BP, 1'b1);
    line_for(1'b1, 2 * BP);
    check_rx("t5");

    // Sender rate +/-3%
    send_frame(8'h96, 421, 1'b1);
    line_for(1'b1, BP);
    send_frame(8'h96, 447, 1'b1);
    line_for(1'b1, 2 * BP);
    check_rx("t6");

    // Random bytes, rates and gaps
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom);
      bp = 425 + int'($urandom_range(0, 18));
      send_frame(rb, bp, 1'b1);
      line_for(1'b1, int'($urandom_range(0, 2)) * bp);
    end
    line_for(1'b1, 2 * BP);
    check_rx("rand");

    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
